regfile_mp: RTL and testbench

- Parametrised multi-port register file; successor to the single-write, two-read pipeline regfile.
- Configurable data width, depth, read-port count and write-port count.
- Optional hardwired-zero entry 0 and write-to-read bypass.
- Per-entry busy scoreboard: set at issue, cleared at writeback, so the ID stage can detect pending producers.

---
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with optional zero entry, write-to-read
//            bypass and a per-entry busy scoreboard for pending producers.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_idx,
    input  logic [NUM_WR*WIDTH-1:0]  wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_idx,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_idx,
    output logic                     busy_any
);

    localparam logic c_zero_en = (ZERO_REG != 0);
    localparam logic c_byp_en  = (BYPASS != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_wr_dec;

    // Later write ports override earlier ones through NBA ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && !(c_zero_en && wr_idx[p*AW +: AW] == '0)) begin
                    r_mem[wr_idx[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_wr_dec = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                w_wr_dec[wr_idx[p*AW +: AW]] = 1'b1;
            end
        end
    end

    // A same-cycle issue supersedes the writeback that would clear the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (c_zero_en && i == 0) begin
                    r_busy[i] <= 1'b0;
                end else if (issue_en && issue_idx == AW'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_dec[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_any = |r_busy;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [AW-1:0]    w_idx;
        logic             w_hit;
        logic             w_zero;
        logic [WIDTH-1:0] w_fwd;

        assign w_idx  = rd_idx[r*AW +: AW];
        assign w_zero = c_zero_en && (w_idx == '0);

        always_comb begin
            w_hit = 1'b0;
            w_fwd = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_idx[p*AW +: AW] == w_idx) begin
                    w_hit = 1'b1;
                    w_fwd = wr_data[p*WIDTH +: WIDTH];
                end
            end
        end

        assign rd_data[r*WIDTH +: WIDTH] = w_zero               ? '0    :
                                           (c_byp_en && w_hit)  ? w_fwd :
                                                                  r_mem[w_idx];
        assign rd_busy[r] = !w_zero && r_busy[w_idx] && !(c_byp_en && w_hit);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed, table-driven bench for regfile_mp (two write ports).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_idx;
    logic [2*WIDTH-1:0] wr_data;
    logic [2*AW-1:0]   rd_idx;
    logic [2*WIDTH-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic              issue_en;
    logic [AW-1:0]     issue_idx;
    logic              busy_any;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(
        .WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_en(issue_en), .issue_idx(issue_idx), .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wi0, wi1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ri0, ri1;
        logic        ie;
        logic [4:0]  ii;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        logic        ea;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [1:0] we,
                       input logic [4:0] wi0, input logic [31:0] wd0,
                       input logic [4:0] wi1, input logic [31:0] wd1,
                       input logic [4:0] ri0, input logic [4:0] ri1,
                       input logic ie, input logic [4:0] ii,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] eb, input logic ea);
        vec_t v;
        v.rst = r; v.we = we; v.wi0 = wi0; v.wd0 = wd0; v.wi1 = wi1; v.wd1 = wd1;
        v.ri0 = ri0; v.ri1 = ri1; v.ie = ie; v.ii = ii;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] e0,
                         input logic [31:0] e1, input logic [1:0] eb, input logic ea);
        n_tests++;
        if (rd_data[31:0] !== e0 || rd_data[63:32] !== e1 ||
            rd_busy !== eb || busy_any !== ea) begin
            n_fail++;
            $display("FAIL %s: got d0=%h d1=%h busy=%b any=%b, expected d0=%h d1=%h busy=%b any=%b",
                     name, rd_data[31:0], rd_data[63:32], rd_busy, busy_any, e0, e1, eb, ea);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = '0; wr_idx = '0; wr_data = '0;
        rd_idx = '0; issue_en = 1'b0; issue_idx = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset sweep of every entry on both read ports.
        for (int i = 0; i < 32; i++) begin
            rd_idx = {5'(31 - i), 5'(i)};
            @(negedge clk);
            check($sformatf("reset_sweep_%0d", i), 32'h0, 32'h0, 2'b00, 1'b0);
            @(posedge clk); #1;
        end

        //   rst we  wi0  wd0           wi1  wd1           ri0 ri1 ie ii   e0            e1            eb     ea
        add(0, 2'b01, 5, 32'hDEADBEEF, 0, 32'h0,        5,  6,  0, 0,  32'hDEADBEEF, 32'h0,        2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        5,  5,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        add(0, 2'b01, 0, 32'h1234,     0, 32'h0,        0,  5,  1, 0,  32'h0,        32'hDEADBEEF, 2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        2'b00, 0);
        add(0, 2'b11, 7, 32'hAAAA,     7, 32'hBBBB,     7,  7,  0, 0,  32'hBBBB,     32'hBBBB,     2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        7,  5,  0, 0,  32'hBBBB,     32'hDEADBEEF, 2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        3,  3,  1, 3,  32'h0,        32'h0,        2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        3,  3,  0, 0,  32'h0,        32'h0,        2'b11, 1);
        add(0, 2'b10, 0, 32'h0,        3, 32'h55,       3,  7,  0, 0,  32'h55,       32'hBBBB,     2'b00, 1);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        3,  3,  0, 0,  32'h55,       32'h55,       2'b00, 0);
        add(0, 2'b01, 3, 32'h66,       0, 32'h0,        3,  3,  1, 3,  32'h66,       32'h66,       2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        3,  3,  0, 0,  32'h66,       32'h66,       2'b11, 1);
        add(0, 2'b01, 3, 32'h77,       0, 32'h0,        3,  9,  1, 9,  32'h77,       32'h0,        2'b00, 1);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        3,  9,  0, 0,  32'h77,       32'h0,        2'b10, 1);
        add(1, 2'b01, 12, 32'hCAFE,    0, 32'h0,        3,  7,  1, 12, 32'h77,       32'hBBBB,     2'b00, 1);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        12, 3,  0, 0,  32'h0,        32'h0,        2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        7,  9,  0, 0,  32'h0,        32'h0,        2'b00, 0);
        add(0, 2'b11, 1, 32'h11,       2, 32'h22,       2,  1,  0, 0,  32'h22,       32'h11,       2'b00, 0);
        add(0, 2'b00, 0, 32'h0,        0, 32'h0,        1,  2,  0, 0,  32'h11,       32'h22,       2'b00, 0);

        for (int k = 0; k < tv.size(); k++) begin
            rst       = tv[k].rst;
            wr_en     = tv[k].we;
            wr_idx    = {tv[k].wi1, tv[k].wi0};
            wr_data   = {tv[k].wd1, tv[k].wd0};
            rd_idx    = {tv[k].ri1, tv[k].ri0};
            issue_en  = tv[k].ie;
            issue_idx = tv[k].ii;
            @(negedge clk);
            check($sformatf("vec_%0d", k), tv[k].e0, tv[k].e1, tv[k].eb, tv[k].ea);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
